// File: rtl/muldiv_sched.sv
//==============================================================================
// Module      : muldiv_sched
// Description : Multi-cycle multiply/divide controller for the E stage of a
//               5-stage MIPS pipeline. Owns HI/LO, computes the result when an
//               op is accepted, holds it privately for a fixed latency and then
//               commits it. Drives busy and a combinational stall request for
//               the hazard unit.
// Ports       : clk        - pipeline clock
//               reset      - synchronous, active-high reset
//               start      - E-stage muldiv-class op, E valid
//               op         - 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo
//               srcA, srcB - forwarded rs / rt values
//               useD       - D-stage instruction touches the muldiv unit
//               busy       - multi-cycle operation in progress
//               stall_req  - stall F/D and bubble E
//               hi, lo     - architectural HI / LO registers
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module muldiv_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        useD,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int C_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int C_CNT_W      = $clog2(C_MAX_CYCLES + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [C_CNT_W-1:0]   r_count;
    logic [31:0]          r_pend_hi;
    logic [31:0]          r_pend_lo;
    logic                 r_pend_we;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;

    // Arithmetic datapath (evaluated every cycle, captured only on accept)
    logic                 w_is_arith;
    logic                 w_div0;
    logic                 w_ovf;
    logic [31:0]          w_divisor;
    logic signed [63:0]   w_prod_s;
    logic [63:0]          w_prod_u;
    logic signed [31:0]   w_quot_s;
    logic signed [31:0]   w_rem_s;
    logic [31:0]          w_quot_u;
    logic [31:0]          w_rem_u;
    logic [31:0]          w_res_hi;
    logic [31:0]          w_res_lo;
    logic                 w_res_we;

    assign w_is_arith = start && (op <= 3'd3);
    assign w_div0     = (srcB == 32'd0);
    assign w_ovf      = (srcA == 32'h8000_0000) && (srcB == 32'hFFFF_FFFF);

    // A zero divisor is replaced so the dividers never see it; the result is
    // discarded anyway through w_res_we.
    assign w_divisor  = w_div0 ? 32'd1 : srcB;

    assign w_prod_s = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
    assign w_prod_u = {32'd0, srcA} * {32'd0, srcB};
    assign w_quot_s = $signed(srcA) / $signed(w_divisor);
    assign w_rem_s  = $signed(srcA) % $signed(w_divisor);
    assign w_quot_u = srcA / w_divisor;
    assign w_rem_u  = srcA % w_divisor;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_res_we = 1'b1;
        case (op[1:0])
            2'd0: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            2'd1: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            2'd2: begin
                if (w_div0) begin
                    w_res_we = 1'b0;
                end else if (w_ovf) begin
                    // Quotient wraps to the most negative value, remainder 0.
                    w_res_hi = 32'd0;
                    w_res_lo = 32'h8000_0000;
                end else begin
                    w_res_hi = w_rem_s;
                    w_res_lo = w_quot_s;
                end
            end
            default: begin
                if (w_div0) begin
                    w_res_we = 1'b0;
                end else begin
                    w_res_hi = w_rem_u;
                    w_res_lo = w_quot_u;
                end
            end
        endcase
    end

    // Sequencer: IDLE accepts ops, RUN counts down the fixed latency and
    // commits the pending result on the last busy cycle's edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_we <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_arith) begin
                        r_pend_hi <= w_res_hi;
                        r_pend_lo <= w_res_lo;
                        r_pend_we <= w_res_we;
                        r_count   <= op[1] ? C_CNT_W'(DIV_CYCLES) : C_CNT_W'(MULT_CYCLES);
                        r_state   <= S_RUN;
                    end else if (start && (op == 3'd4)) begin
                        r_hi <= srcA;
                    end else if (start && (op == 3'd5)) begin
                        r_lo <= srcA;
                    end
                end
                S_RUN: begin
                    // Any start seen here is ignored: no HI/LO or state change.
                    if (r_count == C_CNT_W'(1)) begin
                        if (r_pend_we) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_count <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_count <= r_count - C_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign busy      = (r_state == S_RUN);
    assign hi        = r_hi;
    assign lo        = r_lo;

    // Combinational so the D-stage consumer is held in the same cycle the
    // multi-cycle op sits in E, before busy has had a chance to rise.
    assign stall_req = useD & (busy | w_is_arith);

endmodule

`default_nettype wire
